muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the HI/LO multiply/divide unit.
// CPU decode imports the same constants so both sides agree on op_in.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// One shared 2*WIDTH shift register serves as product accumulator or remainder:quotient.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO complete here directly
// CALC  | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written on the exit edge
// DONE  | one-cycle completion; may accept the next request
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit MTX_DONE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             flush_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             divzero_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             bzero_q, bzero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_diff;
    logic [AW-1:0]    prod_raw, prod_fix;
    logic [WIDTH-1:0] quo_raw, quo_fix;
    logic [WIDTH-1:0] rem_raw, rem_fix;

    always_comb begin
        accept = start_in && !flush_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        a_neg  = op_is_signed(op_in) && a_in[WIDTH-1];
        b_neg  = op_is_signed(op_in) && b_in[WIDTH-1];
        a_abs  = a_neg ? -a_in : a_in;
        b_abs  = b_neg ? -b_in : b_in;

        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        div_part = acc_q[AW-1:WIDTH-1];
        div_diff = div_part - {1'b0, opb_q};

        prod_raw = acc_q;
        prod_fix = neg_lo_q ? -prod_raw : prod_raw;
        quo_raw  = acc_q[WIDTH-1:0];
        quo_fix  = neg_lo_q ? -quo_raw : quo_raw;
        rem_raw  = acc_q[AW-1:WIDTH];
        rem_fix  = neg_hi_q ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        bzero_d   = bzero_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept && op_is_arith(op_in)) begin
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    is_div_d = op_is_div(op_in);
                    if (op_is_div(op_in)) begin
                        acc_d    = {{WIDTH{1'b0}}, a_abs};
                        opb_d    = b_abs;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        bzero_d  = (b_in == '0);
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, b_abs};
                        opb_d    = a_abs;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg ^ b_neg;
                        bzero_d  = 1'b0;
                    end
                end else if (accept && (op_in == OP_MTHI)) begin
                    hi_d   = a_in;
                    done_d = MTX_DONE;
                end else if (accept && (op_in == OP_MTLO)) begin
                    lo_d   = a_in;
                    done_d = MTX_DONE;
                end
            end
            ST_CALC: begin
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[AW-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        if (bzero_q) begin
                            divzero_d = 1'b1;
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end
                    end else begin
                        hi_d = prod_fix[AW-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign divzero_out = divzero_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): expected HI/LO from a behavioural model
// are queued at issue and popped when done_out arrives.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_in = 1'b0;
    logic         start_in = 1'b0;
    logic [2:0]   op_in = 3'd0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         flush_in = 1'b0;
    logic         busy_out, done_out, divzero_out;
    logic [W-1:0] hi_out, lo_out;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         scb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           total = 0;
    int           bad = 0;

    muldiv_unit #(.WIDTH(W), .MTX_DONE(1'b1)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .start_in   (start_in),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .flush_in   (flush_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .divzero_out(divzero_out),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference results from native wide arithmetic; divide by zero keeps HI/LO.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, p, q, r;
        logic [63:0] ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = 1'b0;
        case (op)
            OP_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MULTU: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
            OP_DIV: begin
                if (b == '0) e.dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; end
            end
            OP_DIVU: begin
                if (b == '0) e.dz = 1'b1;
                else begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
            end
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        exp_t e;
        int   n;
        int   busy_n;
        scb.push_back(model(op, a, b));
        @(negedge clk);
        start_in = 1'b1; op_in = op; a_in = a; b_in = b;
        @(negedge clk);
        start_in = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done_out && n < 100) begin
            if (busy_out) busy_n++;
            if (poke && n == 5) begin
                start_in = 1'b1; op_in = OP_MTHI; a_in = 32'h0BAD_0BAD;
            end else begin
                start_in = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_in = 1'b0;
        e = scb.pop_front();
        check_int({tag, "_latency"}, n, W + 1);
        check_int({tag, "_busy_cycles"}, busy_n, W + 1);
        check1({tag, "_done"}, done_out, 1'b1);
        check1({tag, "_divzero"}, divzero_out, e.dz);
        check({tag, "_hi"}, hi_out, e.hi);
        check({tag, "_lo"}, lo_out, e.lo);
        @(negedge clk);
        check1({tag, "_done_pulse"}, done_out, 1'b0);
        check1({tag, "_busy_after"}, busy_out, 1'b0);
    endtask

    task automatic run_mtx(input string tag, input logic [2:0] op, input logic [W-1:0] a);
        @(negedge clk);
        start_in = 1'b1; op_in = op; a_in = a;
        @(negedge clk);
        start_in = 1'b0;
        if (op == OP_MTHI) m_hi = a;
        if (op == OP_MTLO) m_lo = a;
        check({tag, "_hi"}, hi_out, m_hi);
        check({tag, "_lo"}, lo_out, m_lo);
        check1({tag, "_done"}, done_out, (op == OP_MTHI) || (op == OP_MTLO));
        check1({tag, "_busy"}, busy_out, 1'b0);
        @(negedge clk);
        check1({tag, "_done_pulse"}, done_out, 1'b0);
    endtask

    initial begin
        int dcount;
        #12;
        check("rst_hi", hi_out, '0);
        check("rst_lo", lo_out, '0);
        check1("rst_busy", busy_out, 1'b0);
        check1("rst_done", done_out, 1'b0);
        check1("rst_divzero", divzero_out, 1'b0);
        @(negedge clk);
        reset_in = 1'b1;

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg_hi_const", hi_out, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", lo_out, 32'hFFFF_FFEB);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi_const", hi_out, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo_out, 32'h0000_0001);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_lo_const", lo_out, 32'hFFFF_FFFD);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", lo_out, 32'h8000_0000);
        check("div_ovf_hi_const", hi_out, 32'h0000_0000);
        run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1'b0);
        check("divu_zero_hi_kept", hi_out, 32'h0000_0000);
        run_op("div_mixed", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFEDC_BA98, 32'h0000_1234, 1'b0);
        run_op("div_zero_s", OP_DIV, 32'h8000_0000, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_op("mult_rnd", OP_MULT, $urandom, $urandom, 1'b0);
            run_op("div_rnd", OP_DIV, $urandom, $urandom_range(1, 32'h0000_FFFF), 1'b0);
        end

        run_mtx("mthi", OP_MTHI, 32'h0000_1234);
        run_mtx("mtlo", OP_MTLO, 32'hCAFE_F00D);
        run_mtx("undef_op", 3'd6, 32'h5555_AAAA);

        run_op("busy_poke", OP_MULTU, 32'd1000, 32'd3000, 1'b1);
        check("busy_poke_hi_kept", hi_out, 32'd0);

        // Flush at CALC cycle 10 abandons the operation.
        @(negedge clk);
        start_in = 1'b1; op_in = OP_MULT; a_in = 32'd3; b_in = 32'd5;
        @(negedge clk);
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        check1("flush_busy", busy_out, 1'b0);
        check1("flush_done", done_out, 1'b0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_out) dcount++;
        end
        check_int("flush_no_done", dcount, 0);
        check("flush_hi", hi_out, m_hi);
        check("flush_lo", lo_out, m_lo);

        @(negedge clk);
        start_in = 1'b1; flush_in = 1'b1; op_in = OP_MTLO; a_in = 32'h0000_DEAD;
        @(negedge clk);
        start_in = 1'b0; flush_in = 1'b0;
        check("flush_prio_lo", lo_out, m_lo);
        check1("flush_prio_done", done_out, 1'b0);

        // Reset in the middle of CALC.
        @(negedge clk);
        start_in = 1'b1; op_in = OP_MULTU; a_in = 32'd77; b_in = 32'd99;
        @(negedge clk);
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        reset_in = 1'b0;
        #1;
        check("midrst_hi", hi_out, '0);
        check("midrst_lo", lo_out, '0);
        check1("midrst_busy", busy_out, 1'b0);
        check1("midrst_done", done_out, 1'b0);
        check1("midrst_divzero", divzero_out, 1'b0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_in = 1'b1;

        run_op("post_rst", OP_DIVU, 32'd100, 32'd7, 1'b0);
        check("post_rst_lo_const", lo_out, 32'd14);
        check("post_rst_hi_const", hi_out, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
